// File: rtl/avl_bus_arbiter_if.sv
// i_avl_bus: request/response bus shared by the core ports and memory.
// master drives commands and resp_ready; slave returns data and ready.
interface i_avl_bus;
   logic [31:0] address;
   logic [3:0]  byte_en;
   logic        read;
   logic        write;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        read_data_valid;
   logic        request_ready;
   logic        resp_ready;

   modport master (
      output address, byte_en, read, write, write_data, resp_ready,
      input  read_data, read_data_valid, request_ready
   );

   modport slave (
      input  address, byte_en, read, write, write_data, resp_ready,
      output read_data, read_data_valid, request_ready
   );
endinterface

// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter: shares one memory port between fetch (s0) and data (s1).
// Ports: clk, rest (async high), avl_s0/avl_s1 requesters, avl_m0 memory.
module avl_bus_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter bit          FIXED_PRIORITY  = 1'b0
) (
   input  logic     clk,
   input  logic     rest,
   i_avl_bus.slave  avl_s0,
   i_avl_bus.slave  avl_s1,
   i_avl_bus.master avl_m0
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   logic                       req0;
   logic                       req1;
   logic                       g;
   logic                       last;
   logic                       g_read;
   logic                       g_write;
   logic                       g_rdy;
   logic                       acc;
   logic                       push;
   logic                       pop;
   logic                       nz;
   logic                       head;
   logic                       rd_block;
   logic                       resp_rdy;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [CW-1:0]              count;
   logic [MAX_OUTSTANDING-1:0] ids;

   assign req0 = avl_s0.read | avl_s0.write;
   assign req1 = avl_s1.read | avl_s1.write;

   // last=1 after reset, so s0 wins the first contended cycle
   always_comb begin
      g = 1'b0;
      if (FIXED_PRIORITY)
         g = !req0 && req1;
      else if (req0 && req1)
         g = !last;
      else
         g = req1;
   end

   assign nz       = (count != '0);
   assign head     = ids[rd_ptr];
   assign resp_rdy = nz ? (head ? avl_s1.resp_ready : avl_s0.resp_ready)
                        : 1'b1;
   assign pop      = avl_m0.read_data_valid & resp_rdy & nz;
   // a pop this cycle frees a slot, so a full FIFO may still take a read
   assign rd_block = (count == CW'(MAX_OUTSTANDING)) & !pop;

   assign g_read  = g ? avl_s1.read  : avl_s0.read;
   assign g_write = g ? avl_s1.write : avl_s0.write;
   assign g_rdy   = avl_m0.request_ready & !(g_read & rd_block);
   assign acc     = (g_read | g_write) & g_rdy;
   assign push    = acc & g_read;

   assign avl_m0.address    = g ? avl_s1.address    : avl_s0.address;
   assign avl_m0.byte_en    = g ? avl_s1.byte_en    : avl_s0.byte_en;
   assign avl_m0.write_data = g ? avl_s1.write_data : avl_s0.write_data;
   assign avl_m0.write      = g_write;
   assign avl_m0.read       = g_read & !rd_block;
   assign avl_m0.resp_ready = resp_rdy;

   assign avl_s0.request_ready = !g & g_rdy;
   assign avl_s1.request_ready =  g & g_rdy;

   assign avl_s0.read_data       = avl_m0.read_data;
   assign avl_s1.read_data       = avl_m0.read_data;
   assign avl_s0.read_data_valid = avl_m0.read_data_valid & nz & !head;
   assign avl_s1.read_data_valid = avl_m0.read_data_valid & nz &  head;

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         last   <= 1'b1;
      end else begin
         if (acc)
            last <= g;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ID storage needs no reset: entries are only read while count != 0
   always_ff @(posedge clk) begin
      if (push)
         ids[wr_ptr] <= g;
   end

endmodule
